pipe_intr_sequencer: RTL

//  Pipeline control sequencer for the 8-bit pipelined core. Drives stall/flush for IF/ID and ID/EX registers.

---
 rtl/pipe_intr_sequencer_pkg.sv | 27 ++
 rtl/pipe_intr_sequencer_if.sv | 19 +
 rtl/pipe_intr_sequencer_edge.sv | 29 ++
 rtl/pipe_intr_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipe_intr_sequencer_pkg.sv
// Shared state encodings, default vector addresses and the pipeline-control bundle
// used by the interrupt/reset-vector sequencer.
package pipe_intr_sequencer_pkg;

  localparam logic [2:0] S_RST_VEC = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_PUSH    = 3'd3;
  localparam logic [2:0] S_VEC     = 3'd4;

  localparam logic [7:0] DEF_RESET_VEC_ADDR = 8'h00;
  localparam logic [7:0] DEF_INTR_VEC_ADDR  = 8'h01;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic flush_d;
    logic flush_e;
  } pipe_ctl_t;

  // HOLD freezes fetch/decode and bubbles EX; ALL additionally clears IF/ID.
  localparam pipe_ctl_t CTL_NONE   = 4'b0000;
  localparam pipe_ctl_t CTL_HOLD   = 4'b1101;
  localparam pipe_ctl_t CTL_BRANCH = 4'b0011;
  localparam pipe_ctl_t CTL_ALL    = 4'b1111;

endpackage

// File: rtl/pipe_intr_sequencer_if.sv
// Sequencer-side data-memory port: request/write/address/data out, grant and read data back.
interface pipe_intr_sequencer_if;
  logic       seq_mem_req;
  logic       seq_mem_we;
  logic [7:0] seq_mem_addr;
  logic [7:0] seq_mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (
    output seq_mem_req, seq_mem_we, seq_mem_addr, seq_mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  seq_mem_req, seq_mem_we, seq_mem_addr, seq_mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/pipe_intr_sequencer_edge.sv
// Rising-edge detector for the external interrupt with a single pending flag.
// An edge arriving in the same cycle as acceptance re-arms pend, so it is not lost.
module intr_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic intr_req_i,
  input  logic accept_i,
  output logic pend_o
);
  logic intr_q;
  logic pend_q;
  logic pend_d;

  always_comb begin
    pend_d = (intr_req_i & ~intr_q) | (pend_q & ~accept_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intr_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      intr_q <= intr_req_i;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
endmodule

// File: rtl/pipe_intr_sequencer.sv
// Pipeline stall/flush sequencer: reset-vector fetch, interrupt entry (drain, push PC,
// load vector) and IDLE routing of branch / load-use hazards. Memory handshake waits on ack.
module pipe_intr_sequencer
  import pipe_intr_sequencer_pkg::*;
#(
  parameter logic [7:0]  RESET_VEC_ADDR = DEF_RESET_VEC_ADDR,
  parameter logic [7:0]  INTR_VEC_ADDR  = DEF_INTR_VEC_ADDR,
  parameter int unsigned DRAIN_CYCLES   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          intr_req,
  input  logic                          ld_use_hazard,
  input  logic                          branch_taken_E,
  input  logic                          ret_in_flight,
  input  logic [7:0]                    pc_D,
  input  logic [7:0]                    sp_in,
  pipe_intr_sequencer_if.master         mem,
  output logic                          stall_F,
  output logic                          stall_D,
  output logic                          flush_D,
  output logic                          flush_E,
  output logic                          pc_load,
  output logic [7:0]                    pc_load_val,
  output logic                          sp_dec,
  output logic                          f_save,
  output logic                          intr_busy
);
  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] saved_pc_q, saved_pc_d;
  logic       pend;
  logic       accept;
  pipe_ctl_t  ctl;
  logic       req, we;
  logic [7:0] addr, wdata;

  intr_edge_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .intr_req_i (intr_req),
    .accept_i   (accept),
    .pend_o     (pend)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    saved_pc_d  = saved_pc_q;
    accept      = 1'b0;
    ctl         = CTL_NONE;
    req         = 1'b0;
    we          = 1'b0;
    addr        = 8'h00;
    wdata       = 8'h00;
    pc_load     = 1'b0;
    pc_load_val = 8'h00;
    sp_dec      = 1'b0;
    f_save      = 1'b0;
    case (state_q)
      S_RST_VEC: begin
        ctl  = CTL_ALL;
        req  = 1'b1;
        addr = RESET_VEC_ADDR;
        if (mem.mem_ack) begin
          pc_load     = 1'b1;
          pc_load_val = mem.mem_rdata;
          state_d     = S_IDLE;
        end
      end
      S_IDLE: begin
        // A taken branch squashes the decode instruction, so its PC is not a valid return point.
        if (branch_taken_E) begin
          ctl = CTL_BRANCH;
        end else if (pend && !ret_in_flight) begin
          accept     = 1'b1;
          ctl        = CTL_HOLD;
          saved_pc_d = pc_D;
          cnt_d      = DRAIN_INIT;
          state_d    = (DRAIN_CYCLES == 0) ? S_PUSH : S_DRAIN;
        end else if (ld_use_hazard) begin
          ctl = CTL_HOLD;
        end
      end
      S_DRAIN: begin
        ctl   = CTL_HOLD;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) state_d = S_PUSH;
      end
      S_PUSH: begin
        ctl   = CTL_HOLD;
        req   = 1'b1;
        we    = 1'b1;
        addr  = sp_in;
        wdata = saved_pc_q;
        if (mem.mem_ack) begin
          sp_dec  = 1'b1;
          f_save  = 1'b1;
          state_d = S_VEC;
        end
      end
      S_VEC: begin
        ctl  = CTL_HOLD;
        req  = 1'b1;
        addr = INTR_VEC_ADDR;
        if (mem.mem_ack) begin
          ctl         = CTL_ALL;
          pc_load     = 1'b1;
          pc_load_val = mem.mem_rdata;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_RST_VEC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RST_VEC;
      cnt_q      <= 8'h00;
      saved_pc_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  assign stall_F           = ctl.stall_f;
  assign stall_D           = ctl.stall_d;
  assign flush_D           = ctl.flush_d;
  assign flush_E           = ctl.flush_e;
  assign intr_busy         = (state_q != S_IDLE);
  assign mem.seq_mem_req   = req;
  assign mem.seq_mem_we    = we;
  assign mem.seq_mem_addr  = addr;
  assign mem.seq_mem_wdata = wdata;
endmodule
